// File: rtl/weight_stream_pkg.sv
// Shared types and helpers for the weight streaming sequencer.
package weight_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // Default ROM read latency (address+ce to valid data).
    localparam int RD_LAT_DEFAULT = 2;

    // A read may be issued only if every outstanding word already has a FIFO slot reserved.
    function automatic logic credit_ok(input int unsigned inflight,
                                       input int unsigned fifo_count,
                                       input int unsigned fifo_depth);
        return (inflight + fifo_count) < fifo_depth;
    endfunction

endpackage

// File: rtl/weight_stream_ctrl_if.sv
// Valid/ready stream carrying ROM words to the downstream consumer.
interface weight_stream_ctrl_if
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );
endinterface

// File: rtl/weight_stream_fifo.sv
// Small synchronous FIFO that absorbs ROM words while the consumer stalls.
module weight_stream_fifo
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  head_valid,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop     = pop && !empty;
    // A pop in the same cycle frees the slot, so push-on-full is legal then.
    assign do_push    = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is clean after reset.
    assign head       = empty ? '0 : mem[rd_ptr];
    assign head_valid = !empty;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; data needs no reset because occupancy gates its use.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Credit logic upstream must never present a word the FIFO cannot take.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(push && full && !do_pop))
                else $error("weight_stream_fifo: push into full FIFO");
        end
    end

endmodule

// File: rtl/weight_stream_ctrl.sv
// Sequencer that streams a latency-2 weight ROM for a number of passes
// into a valid/ready consumer, using read credits so nothing is dropped.
module weight_stream_ctrl
    import weight_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 576,
    parameter int ADDR_WIDTH   = $clog2(DEPTH) + 1,
    parameter int READ_LATENCY = RD_LAT_DEFAULT,
    parameter int FIFO_DEPTH   = 4,
    parameter int PASS_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] num_passes,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [PASS_WIDTH-1:0] pass_idx,
    weight_stream_ctrl_if.master  stream
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be at least READ_LATENCY+2 for full throughput");
    end

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [PASS_WIDTH-1:0]   num_passes_q;
    logic [READ_LATENCY-1:0] vld_p;
    logic                    drain_armed;
    logic [INF_W-1:0]        inflight;
    logic [CNT_W-1:0]        fifo_count;
    logic                    issue;
    logic                    last_issue;
    logic                    drain_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = (num_passes == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                if (issue && last_issue) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs and issue strobe derived from state and registered counters.
    always_comb begin
        issue      = (state == STREAM) &&
                     credit_ok(32'(inflight), 32'(fifo_count), 32'(FIFO_DEPTH));
        last_issue = (addr == LAST_ADDR) &&
                     (pass_idx == num_passes_q - PASS_WIDTH'(1));
        // drain_armed guarantees at least one busy cycle in DRAIN, even for empty jobs.
        drain_done = (state == DRAIN) && drain_armed &&
                     (inflight == '0) && (fifo_count == '0);
        done       = drain_done;
        busy       = (state == STREAM) || ((state == DRAIN) && !drain_done);
        rom_ce     = busy;
        rom_addr   = addr;
    end

    // Count reads still travelling through the ROM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(vld_p[i]);
        end
    end

    // Address/pass counters, job latch and the read-valid shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr         <= '0;
            pass_idx     <= '0;
            num_passes_q <= '0;
            vld_p        <= '0;
            drain_armed  <= 1'b0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            drain_armed <= (state == DRAIN);
            if (state == IDLE && start) begin
                num_passes_q <= num_passes;
                addr         <= '0;
                pass_idx     <= '0;
            end else if (issue) begin
                if (addr == LAST_ADDR) begin
                    addr     <= '0;
                    pass_idx <= pass_idx + PASS_WIDTH'(1);
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    weight_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (vld_p[READ_LATENCY-1]),
        .push_data  (rom_q),
        .pop        (stream.data_out_ready),
        .head       (stream.data_out),
        .head_valid (stream.data_out_valid),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl with an 8-word ROM holding word i = i.
module tb_weight_stream_ctrl;
    localparam int DW = 16;
    localparam int DEPTH = 8;
    localparam int AW = $clog2(DEPTH) + 1;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] num_passes;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic [DW-1:0] rom_q = '0;
    logic [PW-1:0] pass_idx;
    logic          ready;
    logic [AW-1:0] a_d1 = '0;

    int checks = 0;
    int errors = 0;

    weight_stream_ctrl_if #(.DATA_WIDTH(DW)) stream_bus ();
    assign stream_bus.data_out_ready = ready;

    weight_stream_ctrl #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (2),
        .FIFO_DEPTH   (4),
        .PASS_WIDTH   (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_passes (num_passes),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_ce     (rom_ce),
        .rom_q      (rom_q),
        .pass_idx   (pass_idx),
        .stream     (stream_bus.master)
    );

    always #5 clk = ~clk;

    // Two-cycle-latency ROM: word at address i is i.
    always @(posedge clk) begin
        if (rom_ce) begin
            a_d1  <= rom_addr;
            rom_q <= DW'(a_d1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one job. mode 0: ready high, 1: random 30% stall, 2: 20-cycle stall after word 3.
    task automatic stream_job(input int n, input int mode, input string tag);
        int got = 0;
        int dones = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stalled_once = 0;
        bit prev_stall = 0;
        logic [DW-1:0] prev_data = '0;
        logic vld;
        logic [DW-1:0] dat;
        start = 1'b1;
        num_passes = PW'(n);
        step();
        start = 1'b0;
        cyc = 1;
        while (dones == 0 && cyc < 2000) begin
            vld = stream_bus.data_out_valid;
            dat = stream_bus.data_out;
            case (mode)
                0: ready = 1'b1;
                1: ready = ($urandom_range(0, 9) >= 3);
                default: begin
                    if (got == 3 && !stalled_once) begin
                        stall_left = 20;
                        stalled_once = 1;
                    end
                    ready = (stall_left == 0);
                    if (stall_left == 1) begin
                        check({tag, "_outstanding"},
                              32'(int'(pass_idx) * DEPTH + int'(rom_addr) - got), 32'd4);
                    end
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (mode == 0 && cyc == 1) begin
                check({tag, "_busy_c1"}, 32'(busy), 32'd1);
                check({tag, "_romce_c1"}, 32'(rom_ce), 32'd1);
                check({tag, "_addr_c1"}, 32'(rom_addr), 32'd0);
            end
            if (mode == 0 && cyc <= n * DEPTH) begin
                check({tag, "_pass_idx"}, 32'(pass_idx), 32'((cyc - 1) / DEPTH));
            end
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 32'(vld), 32'd1);
                check({tag, "_hold_data"}, 32'(dat), 32'(prev_data));
            end
            check({tag, "_fifo_le4"}, 32'(dut.u_fifo.count <= 3'd4), 32'd1);
            if (vld && ready) begin
                check({tag, "_data"}, 32'(dat), 32'(got % DEPTH));
                if (mode == 0) check({tag, "_data_cycle"}, 32'(cyc), 32'(4 + got));
                got++;
            end
            if (done) begin
                dones++;
                check({tag, "_count_at_done"}, 32'(got), 32'(n * DEPTH));
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                if (mode == 0) check({tag, "_done_cycle"}, 32'(cyc), 32'(4 + n * DEPTH));
            end else begin
                prev_stall = vld && !ready;
                prev_data = dat;
                step();
                cyc++;
            end
        end
        check({tag, "_done_seen"}, 32'(dones), 32'd1);
        step();
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_valid"}, 32'(stream_bus.data_out_valid), 32'd0);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        start = 1'b0;
        num_passes = '0;
        ready = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_ce", 32'(rom_ce), 32'd0);
        check("rst_valid", 32'(stream_bus.data_out_valid), 32'd0);
        check("rst_pass", 32'(pass_idx), 32'd0);
        rst = 1'b1;
        ready = 1'b1;
        step();

        // Basic single pass with ready always high.
        stream_job(1, 0, "basic");

        // Three passes back to back.
        stream_job(3, 0, "multi");

        // Zero passes: one busy cycle, done in cycle 2, no data.
        start = 1'b1;
        num_passes = '0;
        step();
        start = 1'b0;
        check("zero_c1_busy", 32'(busy), 32'd1);
        check("zero_c1_done", 32'(done), 32'd0);
        check("zero_c1_valid", 32'(stream_bus.data_out_valid), 32'd0);
        step();
        check("zero_c2_done", 32'(done), 32'd1);
        check("zero_c2_busy", 32'(busy), 32'd0);
        check("zero_c2_valid", 32'(stream_bus.data_out_valid), 32'd0);
        step();
        check("zero_c3_done", 32'(done), 32'd0);
        check("zero_c3_busy", 32'(busy), 32'd0);

        // Random backpressure.
        stream_job(1, 1, "bp");
        stream_job(2, 1, "bp2");

        // Long stall mid-pass, then release.
        stream_job(2, 2, "stall");

        // Start while busy must be ignored: second start mid-job changes nothing.
        ready = 1'b1;
        start = 1'b1;
        num_passes = PW'(1);
        step();
        num_passes = PW'(5);
        step();
        step();
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            step();
            k++;
        end
        check("ignore_start_len", 32'(k), 32'd9);
        step();

        // Asynchronous reset in the middle of pass 1.
        ready = 1'b1;
        start = 1'b1;
        num_passes = PW'(2);
        step();
        start = 1'b0;
        k = 0;
        while (pass_idx != PW'(1) && k < 100) begin
            step();
            k++;
        end
        check("rstmid_reach_pass1", 32'(pass_idx), 32'd1);
        step();
        #2 rst = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_addr", 32'(rom_addr), 32'd0);
        check("rstmid_ce", 32'(rom_ce), 32'd0);
        check("rstmid_valid", 32'(stream_bus.data_out_valid), 32'd0);
        check("rstmid_data", 32'(stream_bus.data_out), 32'd0);
        check("rstmid_pass", 32'(pass_idx), 32'd0);
        step();
        check("rstmid_hold_done", 32'(done), 32'd0);
        check("rstmid_hold_busy", 32'(busy), 32'd0);
        #2 rst = 1'b1;
        step();
        check("rstmid_after_done", 32'(done), 32'd0);

        // A fresh job after the abort starts again from address 0.
        stream_job(1, 0, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
